// File: rtl/operand_fetch.sv
// Operand fetch: issues register reads, tracks pending writes, hands operands to execute. Build option: OPFETCH_WB_BYPASS_EN.
// Latency: 2 cycles from accept to out_valid; peak throughput 1 instruction per 2 cycles.
// Backpressure: out_valid holds outputs until out_ready; in_ready drops on hazard or stall.
module operand_fetch #(
    parameter int INT32W       = 32,
    parameter int REGFILE_SIZE = 5,
    parameter int PAYLOAD_W    = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [REGFILE_SIZE-1:0] in_rs1,
    input  logic [REGFILE_SIZE-1:0] in_rs2,
    input  logic [REGFILE_SIZE-1:0] in_rd,
    input  logic                    in_rd_we,
    input  logic [PAYLOAD_W-1:0]    in_payload,
    output logic [REGFILE_SIZE-1:0] rf_rs1,
    output logic [REGFILE_SIZE-1:0] rf_rs2,
    input  logic [INT32W-1:0]       rf_data1,
    input  logic [INT32W-1:0]       rf_data2,
    input  logic                    wb_valid,
    input  logic [REGFILE_SIZE-1:0] wb_rd,
    input  logic [INT32W-1:0]       wb_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [INT32W-1:0]       out_op1,
    output logic [INT32W-1:0]       out_op2,
    output logic [REGFILE_SIZE-1:0] out_rd,
    output logic                    out_rd_we,
    output logic [PAYLOAD_W-1:0]    out_payload
);

    localparam int NREG = 1 << REGFILE_SIZE;

    typedef enum logic [1:0] {EMPTY, READ, VALID} state_t;

    state_t                  state;
    logic [NREG-1:0]         pending;
    logic [NREG-1:0]         clr_mask;
    logic [NREG-1:0]         set_mask;
    logic [NREG-1:0]         busy;
    logic [REGFILE_SIZE-1:0] rs1_q;
    logic [REGFILE_SIZE-1:0] rs2_q;
    logic                    wb_clr;
    logic                    hazard;
    logic                    accept;
    logic                    out_fire;
    logic [INT32W-1:0]       op1_sel;
    logic [INT32W-1:0]       op2_sel;

    assign wb_clr   = wb_valid && (wb_rd != '0);
    assign out_fire = out_valid && out_ready;
    assign accept   = in_valid && in_ready;
    assign rf_rs1   = accept ? in_rs1 : rs1_q;
    assign rf_rs2   = accept ? in_rs2 : rs2_q;

    always_comb begin
        clr_mask = '0;
        set_mask = '0;
        if (wb_clr)
            clr_mask[wb_rd] = 1'b1;
        if (out_fire && out_rd_we && (out_rd != '0))
            set_mask[out_rd] = 1'b1;
`ifdef OPFETCH_WB_BYPASS_EN
        busy = pending & ~clr_mask;
`else
        busy = pending;
`endif
        // The instruction issuing this cycle becomes pending on the same edge a follower could be accepted.
        if ((state == VALID) && out_rd_we && (out_rd != '0))
            busy[out_rd] = 1'b1;
    end

    always_comb begin
        hazard = ((in_rs1 != '0) && busy[in_rs1])
              || ((in_rs2 != '0) && busy[in_rs2])
              || (in_rd_we && (in_rd != '0) && busy[in_rd]);
`ifndef OPFETCH_WB_BYPASS_EN
        // The register file returns the old value on a same-edge read/write, so wait a cycle.
        if (wb_clr && (((in_rs1 != '0) && (wb_rd == in_rs1)) || ((in_rs2 != '0) && (wb_rd == in_rs2))))
            hazard = 1'b1;
`endif
    end

    always_comb begin
        case (state)
            EMPTY:   in_ready = ~hazard;
            VALID:   in_ready = out_ready && ~hazard;
            default: in_ready = 1'b0;
        endcase
    end

`ifdef OPFETCH_WB_BYPASS_EN
    logic              byp1_vld;
    logic              byp2_vld;
    logic [INT32W-1:0] byp1_dat;
    logic [INT32W-1:0] byp2_dat;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            byp1_vld <= 1'b0;
            byp2_vld <= 1'b0;
            byp1_dat <= '0;
            byp2_dat <= '0;
        end else if (accept) begin
            byp1_vld <= wb_clr && (wb_rd == in_rs1);
            byp2_vld <= wb_clr && (wb_rd == in_rs2);
            byp1_dat <= wb_data;
            byp2_dat <= wb_data;
        end
    end

    assign op1_sel = (rs1_q == '0) ? '0 : (byp1_vld ? byp1_dat : rf_data1);
    assign op2_sel = (rs2_q == '0) ? '0 : (byp2_vld ? byp2_dat : rf_data2);
`else
    assign op1_sel = (rs1_q == '0) ? '0 : rf_data1;
    assign op2_sel = (rs2_q == '0) ? '0 : rf_data2;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending <= '0;
        end else begin
            pending <= (pending & ~clr_mask) | set_mask;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= EMPTY;
            out_valid   <= 1'b0;
            out_op1     <= '0;
            out_op2     <= '0;
            out_rd      <= '0;
            out_rd_we   <= 1'b0;
            out_payload <= '0;
            rs1_q       <= '0;
            rs2_q       <= '0;
        end else begin
            // Accept only happens from EMPTY or on out fire, so outputs never change under out_valid.
            if (accept) begin
                rs1_q       <= in_rs1;
                rs2_q       <= in_rs2;
                out_rd      <= in_rd;
                out_rd_we   <= in_rd_we;
                out_payload <= in_payload;
            end
            case (state)
                EMPTY: begin
                    if (accept)
                        state <= READ;
                end
                READ: begin
                    out_op1   <= op1_sel;
                    out_op2   <= op2_sel;
                    out_valid <= 1'b1;
                    state     <= VALID;
                end
                VALID: begin
                    if (out_fire) begin
                        out_valid <= 1'b0;
                        state     <= accept ? READ : EMPTY;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

endmodule
